// File: rtl/mant_pkg.sv
// mant_pkg: shared widths and FSM state encoding for the mantissa packing path.
package mant_pkg;
    localparam int MANT_W = 24;
    localparam int EXP_W = 8;
    localparam int FRAC_W = MANT_W - 1;
    localparam int LZC_W = $clog2(MANT_W + 1);
    typedef enum logic [1:0] {ST_IDLE, ST_NORM, ST_OUT} state_t;
endpackage

// File: rtl/mant_lzc.sv
// mant_lzc: combinational leading-zero count; an all-zero input reports MANT_W.
module mant_lzc #(
    parameter int MANT_W = mant_pkg::MANT_W,
    parameter int LZC_W = $clog2(MANT_W + 1)
) (
    input  logic [MANT_W-1:0] mant_i,
    output logic [LZC_W-1:0]  lzc_o
);
    always_comb begin
        lzc_o = LZC_W'(MANT_W);
        for (int i = 0; i < MANT_W; i++)
            if (mant_i[i]) lzc_o = LZC_W'(MANT_W - 1 - i);
    end
endmodule

// File: rtl/mantissa_pack.sv
// mantissa_pack: normalizes a mantissa/exponent pair and strips the hidden bit.
// Define MANTISSA_PACK_FAST_EN for single-cycle normalization via mant_lzc and a barrel shift.
module mantissa_pack #(
    parameter int MANT_W = mant_pkg::MANT_W,
    parameter int EXP_W = mant_pkg::EXP_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sign,
    input  logic [MANT_W-1:0] in_mant,
    input  logic [EXP_W-1:0]  in_exp,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sign,
    output logic [MANT_W-2:0] out_frac,
    output logic [EXP_W-1:0]  out_exp,
    output logic              out_zero,
    output logic              out_denorm
);
    import mant_pkg::*;
    localparam int LW = $clog2(MANT_W + 1);
    state_t state_q, state_d;
    logic sign_q, sign_d, zero_q, zero_d, den_q, den_d;
    logic [MANT_W-1:0] mant_q, mant_d;
    logic [EXP_W-1:0] exp_q, exp_d;
`ifdef MANTISSA_PACK_FAST_EN
    logic [LW-1:0] lz;
    logic [31:0] sh;
    mant_lzc #(.MANT_W(MANT_W), .LZC_W(LW)) u_lzc (.mant_i(mant_q), .lzc_o(lz));
    // Shift is clamped by the exponent so it never goes below zero.
    assign sh = (32'(lz) < 32'(exp_q)) ? 32'(lz) : 32'(exp_q);
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sign_q  <= 1'b0;
            zero_q  <= 1'b0;
            den_q   <= 1'b0;
            mant_q  <= '0;
            exp_q   <= '0;
        end else begin
            state_q <= state_d;
            sign_q  <= sign_d;
            zero_q  <= zero_d;
            den_q   <= den_d;
            mant_q  <= mant_d;
            exp_q   <= exp_d;
        end
    end
    always_comb begin
        state_d = state_q;
        sign_d  = sign_q;
        zero_d  = zero_q;
        den_d   = den_q;
        mant_d  = mant_q;
        exp_d   = exp_q;
        case (state_q)
            ST_IDLE: if (in_valid) begin
                state_d = ST_NORM;
                sign_d  = in_sign;
                mant_d  = in_mant;
                exp_d   = in_exp;
                zero_d  = 1'b0;
                den_d   = 1'b0;
            end
            ST_NORM: begin
`ifdef MANTISSA_PACK_FAST_EN
                state_d = ST_OUT;
                zero_d  = mant_q == '0;
                den_d   = mant_q != '0 && 32'(lz) > 32'(exp_q);
                mant_d  = mant_q << sh;
                exp_d   = (mant_q == '0) ? '0 : exp_q - EXP_W'(sh);
`else
                if (mant_q == '0) begin
                    state_d = ST_OUT;
                    zero_d  = 1'b1;
                    exp_d   = '0;
                end else if (mant_q[MANT_W-1]) begin
                    state_d = ST_OUT;
                end else if (exp_q == '0) begin
                    state_d = ST_OUT;
                    den_d   = 1'b1;
                end else begin
                    mant_d = {mant_q[MANT_W-2:0], 1'b0};
                    exp_d  = exp_q - EXP_W'(1);
                end
`endif
            end
            ST_OUT: if (out_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end
    // The working mantissa doubles as the output fraction once normalized.
    always_comb begin
        in_ready   = state_q == ST_IDLE;
        out_valid  = state_q == ST_OUT;
        out_sign   = sign_q;
        out_frac   = mant_q[MANT_W-2:0];
        out_exp    = exp_q;
        out_zero   = zero_q;
        out_denorm = den_q;
    end
endmodule
